// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 32x8 Data_Memory: one request in,
// one access cycle, one completion pulse per transaction.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] Wdata0,
    output logic              Gnt0,
    output logic              Rvalid0,
    output logic [DATA_W-1:0] Rdata0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Gnt1,
    output logic              Rvalid1,
    output logic [DATA_W-1:0] Rdata1,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Data_in,
    output logic              Mem_En,
    input  logic [DATA_W-1:0] Mem_Data_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              cmd_port_q, cmd_port_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt0_c, gnt1_c;
    logic              winner_c;

    // Tie-break: fixed priority to port 0, or the port not granted last.
    always_comb begin
        winner_c = 1'b0;
        if (Req0 && Req1) begin
            winner_c = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            winner_c = Req1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_port_d  = cmd_port_q;
        last_d      = last_q;
        rdata_d     = rdata_q;
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Req0 || Req1) begin
                    cmd_port_d  = winner_c;
                    last_d      = winner_c;
                    cmd_we_d    = winner_c ? We1    : We0;
                    cmd_addr_d  = winner_c ? Addr1  : Addr0;
                    cmd_wdata_d = winner_c ? Wdata1 : Wdata0;
                    gnt0_c      = ~winner_c;
                    gnt1_c      = winner_c;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!cmd_we_q) begin
                    rdata_d = Mem_Data_out;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_port_q  <= 1'b0;
            last_q      <= 1'b1;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_port_q  <= cmd_port_d;
            last_q      <= last_d;
            rdata_q     <= rdata_d;
        end
    end

    // Reset masks every pulse and the memory strobe in the same cycle,
    // so a write caught by reset in ACCESS never reaches the array.
    assign Gnt0        = gnt0_c & ~Rst;
    assign Gnt1        = gnt1_c & ~Rst;
    assign Rvalid0     = (state_q == ST_DONE) && !cmd_port_q && !Rst;
    assign Rvalid1     = (state_q == ST_DONE) &&  cmd_port_q && !Rst;
    assign Rdata0      = rdata_q;
    assign Rdata1      = rdata_q;
    assign Mem_En      = (state_q == ST_ACCESS) && cmd_we_q && !Rst;
    assign Mem_Addr    = Rst ? '0 : cmd_addr_q;
    assign Mem_Data_in = Rst ? '0 : cmd_wdata_q;

endmodule
